// File: rtl/trunc_pkg.sv
// rtl/trunc_pkg.sv - shared helpers for the truncation-position controller
package trunc_pkg;

  // Ceiling log2 with a floor of 1 so a width derived from it is never zero.
  function automatic int clog2_int(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int pos_min(input int o_width);
    return o_width - 1;
  endfunction

  function automatic int clamp_pos(input int pos, input int o_width, input int i_width);
    if (pos < pos_min(o_width)) return pos_min(o_width);
    if (pos > i_width - 1) return i_width - 1;
    return pos;
  endfunction

endpackage

// File: rtl/lead_one_enc.sv
// rtl/lead_one_enc.sv - combinational leading-one priority encoder
module lead_one_enc #(
  parameter int WIDTH = 29,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] din,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) idx = IDX_W'(i);
    end
  end

  assign zero = (din == '0);

endmodule

// File: rtl/trunc_pos_ctrl.sv
// rtl/trunc_pos_ctrl.sv - block peak tracker that picks the truncator MSB position
module trunc_pos_ctrl
  import trunc_pkg::*;
#(
  parameter int DATA_I_WIDTH = 30,
  parameter int DATA_O_WIDTH = 12,
  parameter int BLOCK_LEN    = 1024,
  parameter int HEADROOM     = 0,
  parameter int POS_W        = clog2_int(DATA_I_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_I_WIDTH-1:0] data_in,
  input  logic                    data_in_valid,
  input  logic                    manual_en,
  input  logic [POS_W-1:0]        manual_pos,
  input  logic                    freeze,
  output logic [POS_W-1:0]        trunc_pos,
  output logic                    trunc_pos_valid,
  output logic                    pos_update,
  output logic                    block_done,
  output logic [POS_W-1:0]        peak_msb,
  output logic                    clip_flag
);

  localparam int MAG_W = DATA_I_WIDTH - 1;
  localparam int CNT_W = clog2_int(BLOCK_LEN);

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] acc;
  logic [MAG_W-1:0] snap;
  logic [CNT_W-1:0] cnt;
  logic             snap_vld;
  logic             last_sample;
  logic [POS_W-1:0] enc_idx;
  logic             snap_zero;
  logic [POS_W-1:0] peak_idx;
  logic [POS_W-1:0] cand;
  logic [POS_W-1:0] manual_clamped;
  logic [POS_W-1:0] pos_nxt;
  logic             pos_valid_nxt;

  // One's-complement magnitude: the most negative input cannot overflow.
  assign mag         = data_in[MAG_W-1:0] ^ {MAG_W{data_in[MAG_W]}};
  assign last_sample = data_in_valid && (cnt == CNT_W'(BLOCK_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      snap     <= '0;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= last_sample;
      if (data_in_valid) begin
        if (last_sample) begin
          snap <= acc | mag;
          acc  <= '0;
          cnt  <= '0;
        end else begin
          acc <= acc | mag;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  lead_one_enc #(
    .WIDTH(MAG_W),
    .IDX_W(POS_W)
  ) u_enc (
    .din (snap),
    .idx (enc_idx),
    .zero(snap_zero)
  );

  assign peak_idx       = snap_zero ? '0 : enc_idx;
  assign cand           = POS_W'(clamp_pos(int'(peak_idx) + 1 + HEADROOM, DATA_O_WIDTH, DATA_I_WIDTH));
  assign manual_clamped = POS_W'(clamp_pos(int'(manual_pos), DATA_O_WIDTH, DATA_I_WIDTH));

  // Manual wins over freeze; auto attacks immediately but decays one bit per block.
  always_comb begin
    pos_nxt       = trunc_pos;
    pos_valid_nxt = trunc_pos_valid;
    if (manual_en) begin
      pos_nxt       = manual_clamped;
      pos_valid_nxt = 1'b1;
    end else if (snap_vld && !freeze) begin
      pos_valid_nxt = 1'b1;
      if (!trunc_pos_valid)      pos_nxt = cand;
      else if (cand > trunc_pos) pos_nxt = cand;
      else if (cand < trunc_pos) pos_nxt = trunc_pos - POS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trunc_pos       <= POS_W'(DATA_I_WIDTH - 1);
      trunc_pos_valid <= 1'b0;
      pos_update      <= 1'b0;
      block_done      <= 1'b0;
      peak_msb        <= '0;
      clip_flag       <= 1'b0;
    end else begin
      trunc_pos       <= pos_nxt;
      trunc_pos_valid <= pos_valid_nxt;
      pos_update      <= (pos_nxt != trunc_pos);
      block_done      <= snap_vld;
      if (snap_vld) peak_msb <= peak_idx;
      clip_flag       <= data_in_valid && ((mag >> trunc_pos) != '0);
    end
  end

endmodule

// File: tb/tb_trunc_pos_ctrl.sv
// tb/tb_trunc_pos_ctrl.sv - directed scoreboard bench for trunc_pos_ctrl
module tb_trunc_pos_ctrl;

  localparam int DW = 30;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          manual_en = 1'b0;
  logic [PW-1:0] manual_pos = '0;
  logic          freeze = 1'b0;
  logic [PW-1:0] trunc_pos;
  logic          trunc_pos_valid;
  logic          pos_update;
  logic          block_done;
  logic [PW-1:0] peak_msb;
  logic          clip_flag;

  typedef struct {
    int pk;
    int pos;
    int upd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  trunc_pos_ctrl #(
    .DATA_I_WIDTH(30),
    .DATA_O_WIDTH(12),
    .BLOCK_LEN   (8),
    .HEADROOM    (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .manual_en      (manual_en),
    .manual_pos     (manual_pos),
    .freeze         (freeze),
    .trunc_pos      (trunc_pos),
    .trunc_pos_valid(trunc_pos_valid),
    .pos_update     (pos_update),
    .block_done     (block_done),
    .peak_msb       (peak_msb),
    .clip_flag      (clip_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every block_done must match the oldest expected block result.
  always @(negedge clk) begin
    if (block_done) begin
      check("blk_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("peak_msb", 32'(peak_msb), 32'(e.pk));
        check("trunc_pos", 32'(trunc_pos), 32'(e.pos));
        check("pos_update", 32'(pos_update), 32'(e.upd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input int v);
    tick();
    data_in       = 30'(v);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic wait_block();
    @(negedge clk);
    check("blk_early", 32'(block_done), 0);
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 0);
  endtask

  task automatic run_block(input int n, input int peak, input int e_pk, input int e_pos, input int e_upd);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) sb.push_back('{e_pk, e_pos, e_upd});
      send_sample((i == n / 2) ? peak : (i % 3) - 1);
    end
    wait_block();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_pos", 32'(trunc_pos), 29);
    check("rst_valid", 32'(trunc_pos_valid), 0);
    check("rst_upd", 32'(pos_update), 0);
    check("rst_blk", 32'(block_done), 0);
    check("rst_peak", 32'(peak_msb), 0);
    check("rst_clip", 32'(clip_flag), 0);

    // First block establishes the position from the reset value.
    run_block(8, 1000, 9, 11, 1);
    check("valid_set", 32'(trunc_pos_valid), 1);
    @(negedge clk);
    check("upd_one_cycle", 32'(pos_update), 0);
    check("blk_one_cycle", 32'(block_done), 0);

    // Attack then single-step decay.
    run_block(8, -70000, 16, 17, 1);
    run_block(8, 1000, 9, 16, 1);

    // Clip detection at trunc_pos=16, inside a frozen block.
    freeze = 1'b1;
    send_sample(1 << 20);
    @(negedge clk);
    check("clip_hi", 32'(clip_flag), 1);
    send_sample(1 << 15);
    @(negedge clk);
    check("clip_lo", 32'(clip_flag), 0);
    @(negedge clk);
    check("clip_idle", 32'(clip_flag), 0);
    run_block(6, 1 << 25, 25, 16, 0);
    freeze = 1'b0;
    run_block(8, 1 << 25, 25, 26, 1);

    // Manual override with clamping at both ends.
    manual_en  = 1'b1;
    manual_pos = 5'd5;
    tick();
    @(negedge clk);
    check("man_lo_pos", 32'(trunc_pos), 11);
    check("man_lo_upd", 32'(pos_update), 1);
    manual_pos = 5'd31;
    @(negedge clk);
    check("man_hi_pos", 32'(trunc_pos), 29);
    check("man_hi_upd", 32'(pos_update), 1);
    @(negedge clk);
    check("man_hold_upd", 32'(pos_update), 0);
    manual_en = 1'b0;
    run_block(8, 1000, 9, 28, 1);

    // Partial block is discarded by a mid-block reset.
    for (int i = 0; i < 5; i++) send_sample(5000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst2_valid", 32'(trunc_pos_valid), 0);
    check("rst2_pos", 32'(trunc_pos), 29);
    run_block(8, 1000, 9, 11, 1);
    repeat (6) tick();
    check("sb_final", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
